text_streamer: RTL

Sequencer for the 1024×8 synchronous-read character ROM. On a start pulse it walks the ROM from a base address for a given length and hands out one character per beat over a valid/ready stream. The stream feeds the UART/console or text-render path. It hides the ROM's one-cycle read latency behind a 2-entry buffer so a continuously ready sink receives one character per clock.

---
 rtl/text_streamer_pkg.sv | 17 +
 rtl/char_fifo2.sv | 81 ++++++++
 rtl/text_streamer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/text_streamer_pkg.sv
// Shared defaults, FSM state type and character constants
// for the text_streamer character ROM sequencer.
package text_streamer_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ts_state_e;

    localparam logic [7:0] NUL_CHAR = 8'h00;

endpackage

// File: rtl/char_fifo2.sv
// 2-entry synchronous FIFO, head entry drives rdata directly.
// Ports: push/wdata in, pop/rdata out, count/empty/full status;
// clk, rst_n (async active-low).
module char_fifo2
    import text_streamer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_pop, do_push;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    // Entries shift toward head so rdata is always head_q.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (do_push) begin
                    head_d = wdata;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    head_d = wdata;
                end else if (do_push) begin
                    tail_d = wdata;
                    cnt_d  = 2'd2;
                end else if (do_pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) begin
                        tail_d = wdata;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rdata = head_q;
    assign count = cnt_q;
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/text_streamer.sv
// Walks the character ROM from base_addr for length entries and
// streams one char per beat on ch_data/ch_valid/ch_ready.
// Ports: clk, rst_n (async active-low), start/base_addr/length in,
// busy/done status, rom_addr/rom_data ROM port, ch_* stream out.
// Optional TEXT_STREAMER_NUL_STOP_EN: a returned 0x00 ends the transfer.
module text_streamer
    import text_streamer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ch_data,
    output logic              ch_valid,
    input  logic              ch_ready
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [LEN_W-1:0]  LEN_ONE = 1;

    ts_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic       push, pop, issue, nul_hit, drained;
    logic       fifo_push, fifo_empty, fifo_full;
    logic [1:0] fifo_count;
    logic [2:0] occ;

    assign pop      = ch_valid & ch_ready;
    assign ch_valid = ~fifo_empty;

    // Slots already committed next cycle: stored + in flight - leaving.
    assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef TEXT_STREAMER_NUL_STOP_EN
    // stop_q drops any read still returning after the NUL.
    logic stop_q, stop_d;
    assign nul_hit = inflight_q & ~stop_q & (rom_data == NUL_CHAR);
    assign push    = inflight_q & ~stop_q & ~nul_hit;
`else
    assign nul_hit = 1'b0;
    assign push    = inflight_q;
`endif

    assign fifo_push = push & (~fifo_full | pop);

    assign issue = (state_q == RUN) && (rem_q != '0)
                 && (occ < 3'd2) && !nul_hit;

    // Nothing left once the current pop empties the FIFO.
    assign drained = ~inflight_q
                   & ((fifo_count == 2'd0)
                   | ((fifo_count == 2'd1) & pop));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        inflight_d = issue;
`ifdef TEXT_STREAMER_NUL_STOP_EN
        stop_d = stop_q;
        if (nul_hit) begin
            stop_d = 1'b1;
        end
`endif
        if (issue) begin
            ptr_d = ptr_q + PTR_ONE;
            rem_d = rem_q - LEN_ONE;
        end
        if (nul_hit) begin
            rem_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d = base_addr;
                    rem_d = length;
`ifdef TEXT_STREAMER_NUL_STOP_EN
                    stop_d = 1'b0;
`endif
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

`ifdef TEXT_STREAMER_NUL_STOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_d;
        end
    end
`endif

    char_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (pop),
        .wdata(rom_data),
        .rdata(ch_data),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_addr = ptr_q;

endmodule
